divide_unit: RTL and testbench

Iterative RV64M integer divider, one quotient bit per clock. Operands come from `o_read_data_1`/`o_read_data_2` of `register_file`. The destination register address travels with the operation. The result is presented with a one-cycle `o_done` pulse that drives the `register_file` write port (`i_write_en_3`, `i_addr_3`, `i_write_data_3`). It covers DIV, DIVU, REM, REMU and their W (32-bit) variants.

---
 rtl/divide_pkg.sv | 19 +
 rtl/divide_unit.sv | 144 ++++++++++++++
 tb/tb_divide_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/divide_pkg.sv
// divide_pkg: shared types for the iterative RV64M divider.
//   div_op_t    : operation encoding carried from decode (DIV/DIVU/REM/REMU)
//   div_state_t : sequencer states of divide_unit
package divide_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DIVIDE = 2'b01,
      FINISH = 2'b10
   } div_state_t;

endpackage

// File: rtl/divide_unit.sv
// divide_unit: iterative restoring RV64M divider, one quotient bit per clock.
//   i_clk, i_arstn     : clock, asynchronous active-low reset
//   i_start, i_flush   : launch (sampled in IDLE when not busy), synchronous abort
//   i_op, i_word       : div_op_t operation, W (half-width) variant
//   i_rs1, i_rs2       : dividend, divisor
//   i_rd_addr          : destination register carried with the operation
//   o_busy, o_done     : operation in flight, one-cycle result-valid pulse
//   o_result, o_rd_addr: quotient/remainder and its destination, held until next o_done
module divide_unit
   import divide_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_arstn,
   input  logic                  i_start,
   input  logic                  i_flush,
   input  logic [1:0]            i_op,
   input  logic                  i_word,
   input  logic [DATA_WIDTH-1:0] i_rs1,
   input  logic [DATA_WIDTH-1:0] i_rs2,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic [ADDR_WIDTH-1:0] o_rd_addr
);

   localparam int W  = DATA_WIDTH;
   localparam int H  = DATA_WIDTH / 2;
   localparam int CW = $clog2(DATA_WIDTH) + 1;

   div_state_t          state;
   div_op_t             op_q;
   logic                word_q;
   logic                neg_q;
   logic                neg_r;
   logic [W:0]          rem;
   logic [W-1:0]        quo;
   logic [W-1:0]        dvs;
   logic [CW-1:0]       cnt;
   logic [ADDR_WIDTH-1:0] rd_q;

   logic                sgn;
   logic [W-1:0]        a_ext;
   logic [W-1:0]        b_ext;
   logic [W-1:0]        a_mag;
   logic [W-1:0]        b_mag;
   logic [W-1:0]        min_neg;
   logic                div0;
   logic                ovf;
   logic                special;
   logic                go;
   logic [W+1:0]        sh;
   logic [W+1:0]        trial;
   logic [W-1:0]        qf;
   logic [W-1:0]        rf;
   logic [W-1:0]        res;
   logic [W-1:0]        res_ext;

   always_comb begin
      sgn     = ~i_op[0];
      // W variants work on the low half, extended according to signedness
      a_ext   = i_word ? {{H{sgn & i_rs1[H-1]}}, i_rs1[H-1:0]} : i_rs1;
      b_ext   = i_word ? {{H{sgn & i_rs2[H-1]}}, i_rs2[H-1:0]} : i_rs2;
      a_mag   = (sgn & a_ext[W-1]) ? -a_ext : a_ext;
      b_mag   = (sgn & b_ext[W-1]) ? -b_ext : b_ext;
      // most-negative value at the active width, as it looks after extension
      min_neg = i_word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
      div0    = b_ext == '0;
      ovf     = sgn & (&b_ext) & (a_ext == min_neg);
      special = div0 | ovf;
      go      = (state == IDLE) & i_start & ~o_busy & ~i_flush;
      // rem never exceeds the divisor, so its top bit only matters after the shift
      sh      = {rem, quo[W-1]};
      trial   = sh - {2'b00, dvs};
      qf      = neg_q ? -quo : quo;
      rf      = neg_r ? -rem[W-1:0] : rem[W-1:0];
      res     = op_q[1] ? rf : qf;
      res_ext = word_q ? {{H{res[H-1]}}, res[H-1:0]} : res;
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state  <= IDLE;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else if (i_flush) begin
         state  <= IDLE;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state  <= go ? (special ? FINISH : DIVIDE) : IDLE;
               o_busy <= go;
               o_done <= 1'b0;
            end
            DIVIDE: state <= (cnt == CW'(W - 1)) ? FINISH : DIVIDE;
            FINISH: begin
               state  <= IDLE;
               o_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         op_q      <= DIV;
         word_q    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         cnt       <= '0;
         rd_q      <= '0;
         o_result  <= '0;
         o_rd_addr <= '0;
      end else if (go) begin
         op_q   <= div_op_t'(i_op);
         word_q <= i_word;
         rd_q   <= i_rd_addr;
         cnt    <= '0;
         dvs    <= b_mag;
         // special cases preload the final unsigned-form results and skip DIVIDE
         quo    <= div0 ? '1 : (ovf ? a_ext : a_mag);
         rem    <= div0 ? {1'b0, a_ext} : '0;
         neg_q  <= ~special & sgn & (a_ext[W-1] ^ b_ext[W-1]);
         neg_r  <= ~special & sgn & a_ext[W-1];
      end else if (state == DIVIDE) begin
         rem <= trial[W+1] ? sh[W:0] : trial[W:0];
         quo <= {quo[W-2:0], ~trial[W+1]};
         cnt <= cnt + 1'b1;
      end else if (state == FINISH && !i_flush) begin
         o_result  <= res_ext;
         o_rd_addr <= rd_q;
      end
   end

endmodule

// File: tb/tb_divide_unit.sv
// tb_divide_unit: directed self-checking bench for divide_unit.
module tb_divide_unit;
   import divide_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_arstn = 1'b0;
   logic        i_start = 1'b0;
   logic        i_flush = 1'b0;
   logic [1:0]  i_op = 2'b00;
   logic        i_word = 1'b0;
   logic [63:0] i_rs1 = '0;
   logic [63:0] i_rs2 = '0;
   logic [4:0]  i_rd_addr = '0;
   logic        o_busy;
   logic        o_done;
   logic [63:0] o_result;
   logic [4:0]  o_rd_addr;

   int vec = 0;
   int miss = 0;

   divide_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
      .i_clk(i_clk), .i_arstn(i_arstn), .i_start(i_start), .i_flush(i_flush),
      .i_op(i_op), .i_word(i_word), .i_rs1(i_rs1), .i_rs2(i_rs2),
      .i_rd_addr(i_rd_addr), .o_busy(o_busy), .o_done(o_done),
      .o_result(o_result), .o_rd_addr(o_rd_addr)
   );

   always #5 i_clk = ~i_clk;

   task automatic launch(input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
      @(negedge i_clk);
      i_op = op; i_word = word; i_rs1 = a; i_rs2 = b; i_rd_addr = rd; i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge i_clk);
         #1;
         if (o_done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic watch_no_done(input int cycles, output logic seen);
      seen = 1'b0;
      repeat (cycles) begin
         @(posedge i_clk);
         #1 seen |= o_done;
      end
   endtask

   task automatic test_vector(input string name, input logic [1:0] op, input logic word,
                              input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                              input logic [63:0] exp, input int exp_lat);
      int lat;
      launch(op, word, a, b, rd);
      vec++;
      if (o_busy !== 1'b1) begin
         miss++; $display("FAIL %s busy: got %b want 1", name, o_busy);
      end
      wait_done(lat);
      vec++;
      if (lat != exp_lat) begin
         miss++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      vec++;
      if (o_result !== exp) begin
         miss++; $display("FAIL %s result: got %h want %h", name, o_result, exp);
      end
      vec++;
      if (o_rd_addr !== rd) begin
         miss++; $display("FAIL %s rd_addr: got %0d want %0d", name, o_rd_addr, rd);
      end
      @(posedge i_clk);
      #1;
      vec++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         miss++; $display("FAIL %s pulse: got done=%b busy=%b want 0 0", name, o_done, o_busy);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge i_clk);
      #1;
      vec++;
      if ({o_busy, o_done, o_result, o_rd_addr} !== '0) begin
         miss++; $display("FAIL reset: got busy=%b done=%b res=%h rd=%0d want all 0",
                          o_busy, o_done, o_result, o_rd_addr);
      end
      @(negedge i_clk);
      i_arstn = 1'b1;
   endtask

   task automatic test_unsigned;
      test_vector("divu_100_7", DIVU, 1'b0, 64'd100, 64'd7, 5'd5, 64'd14, 65);
      test_vector("remu_100_7", REMU, 1'b0, 64'd100, 64'd7, 5'd6, 64'd2, 65);
      test_vector("divu_max", DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 5'd7, 64'd1, 65);
      test_vector("remu_max", REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 5'd8, 64'd1, 65);
   endtask

   task automatic test_signed;
      test_vector("div_m7_2", DIV, 1'b0, -64'sd7, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      test_vector("rem_m7_2", REM, 1'b0, -64'sd7, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      test_vector("div_7_m2", DIV, 1'b0, 64'd7, -64'sd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      test_vector("rem_7_m2", REM, 1'b0, 64'd7, -64'sd2, 5'd13, 64'd1, 65);
   endtask

   task automatic test_div_zero;
      test_vector("divu_by0", DIVU, 1'b0, 64'd5, 64'd0, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      test_vector("rem_by0", REM, 1'b0, 64'd5, 64'd0, 5'd15, 64'd5, 1);
      test_vector("divw_by0", DIV, 1'b1, 64'h1_8000_0000, 64'd0, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 1);
   endtask

   task automatic test_overflow;
      test_vector("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17,
                  64'h8000_0000_0000_0000, 1);
      test_vector("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 64'd0, 1);
      test_vector("divw_ovf", DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd19, 64'hFFFF_FFFF_8000_0000, 1);
   endtask

   task automatic test_word;
      test_vector("divuw", DIVU, 1'b1, 64'hDEAD_0000_8000_0000, 64'd1, 5'd20, 64'hFFFF_FFFF_8000_0000, 65);
      test_vector("remw", REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd21,
                  64'hFFFF_FFFF_FFFF_FFFF, 65);
      test_vector("remuw", REMU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0001_0000, 5'd22,
                  64'h0000_0000_0000_FFFF, 65);
   endtask

   task automatic test_flush;
      logic seen;
      launch(DIVU, 1'b0, 64'd1000, 64'd3, 5'd23);
      repeat (9) @(posedge i_clk);
      #1 i_flush = 1'b1;
      vec++;
      if (o_busy !== 1'b1) begin
         miss++; $display("FAIL flush pre-busy: got %b want 1", o_busy);
      end
      @(posedge i_clk);
      #1 i_flush = 1'b0;
      vec++;
      if (o_busy !== 1'b0) begin
         miss++; $display("FAIL flush busy: got %b want 0", o_busy);
      end
      watch_no_done(80, seen);
      vec++;
      if (seen !== 1'b0) begin
         miss++; $display("FAIL flush no-done: got %b want 0", seen);
      end
   endtask

   task automatic test_flush_start;
      logic seen;
      @(negedge i_clk);
      i_op = DIVU; i_word = 1'b0; i_rs1 = 64'd9; i_rs2 = 64'd0; i_rd_addr = 5'd24;
      i_start = 1'b1; i_flush = 1'b1;
      @(posedge i_clk);
      #1 begin i_start = 1'b0; i_flush = 1'b0; end
      vec++;
      if (o_busy !== 1'b0) begin
         miss++; $display("FAIL flush_start busy: got %b want 0", o_busy);
      end
      watch_no_done(70, seen);
      vec++;
      if (seen !== 1'b0) begin
         miss++; $display("FAIL flush_start no-done: got %b want 0", seen);
      end
   endtask

   task automatic test_async_reset;
      logic seen;
      launch(DIVU, 1'b0, 64'd100, 64'd7, 5'd25);
      repeat (19) @(posedge i_clk);
      #2 i_arstn = 1'b0;
      #1;
      vec++;
      if ({o_busy, o_done, o_result, o_rd_addr} !== '0) begin
         miss++; $display("FAIL async_reset: got busy=%b done=%b res=%h rd=%0d want all 0",
                          o_busy, o_done, o_result, o_rd_addr);
      end
      @(negedge i_clk);
      i_arstn = 1'b1;
      watch_no_done(80, seen);
      vec++;
      if (seen !== 1'b0) begin
         miss++; $display("FAIL async_reset no-done: got %b want 0", seen);
      end
   endtask

   task automatic test_busy_ignore;
      int lat;
      launch(DIVU, 1'b0, 64'd100, 64'd7, 5'd5);
      repeat (4) @(posedge i_clk);
      #1 begin
         i_op = REM; i_rs1 = 64'd1000; i_rs2 = 64'd3; i_rd_addr = 5'd9; i_start = 1'b1;
      end
      @(posedge i_clk);
      #1 i_start = 1'b0;
      wait_done(lat);
      vec++;
      if (lat != 60) begin
         miss++; $display("FAIL ignore latency: got %0d want 60", lat);
      end
      vec++;
      if (o_result !== 64'd14 || o_rd_addr !== 5'd5) begin
         miss++; $display("FAIL ignore result: got %h rd=%0d want 14 rd=5", o_result, o_rd_addr);
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_back_to_back;
      test_vector("b2b_first", DIVU, 1'b0, 64'd81, 64'd9, 5'd26, 64'd9, 65);
      test_vector("b2b_second", REMU, 1'b0, 64'd83, 64'd9, 5'd27, 64'd2, 65);
      test_vector("b2b_hold", DIV, 1'b0, -64'sd100, 64'd0, 5'd28, 64'hFFFF_FFFF_FFFF_FFFF, 1);
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_div_zero;
      test_overflow;
      test_word;
      test_flush;
      test_flush_start;
      test_async_reset;
      test_busy_ignore;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
